// File: rtl/rtl_sync_ftd_pkg.sv
// rtl_sync_ftd_pkg: widths, output scaling, tap coefficients and sample/accumulator types for the FIR
package rtl_sync_ftd_pkg;
    localparam int DIN_W  = 10;
    localparam int DOUT_W = 11;
    localparam int ACC_W  = 17;
    localparam int SHIFT  = 5;
    localparam int NTAPS  = 16;
    // Symmetric low-pass kernel; COEF[k] weights the sample delayed k stages. Sum is 64.
    localparam int COEF [NTAPS] = '{0, 0, 1, -2, 2, 0, -7, 38, 38, -7, 0, 2, -2, 1, 0, 0};
    typedef logic signed [DIN_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/rtl_sync_ftd_fir_tap_mac.sv
// fir_tap_mac: signed sample times a constant signed coefficient, producing an ACC_W product
// Ports: x_i - signed sample; p_o - sign-extended product
module fir_tap_mac
    import rtl_sync_ftd_pkg::*;
#(
    parameter int COEF_V = 0
) (
    input  sample_t x_i,
    output acc_t    p_o
);
    // Both operands widened to ACC_W so the multiply is signed at full accumulator width.
    assign p_o = acc_t'(x_i) * acc_t'(COEF_V);
endmodule

// File: rtl/rtl_sync_ftd.sv
// rtl_sync_ftd: 16-tap direct-form FIR, one sample in and one scaled sample out per clock
// Ports: clk - clock; rst - synchronous active-high reset; din - signed sample; dout - registered filtered output
module rtl_sync_ftd
    import rtl_sync_ftd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] dout
);
    sample_t             tap_q [NTAPS];
    acc_t                prod  [NTAPS];
    acc_t                acc;
    logic [DOUT_W-1:0]   dout_d;
    logic [DOUT_W-1:0]   dout_q;

    for (genvar g = 0; g < NTAPS; g++) begin : g_mac
        fir_tap_mac #(.COEF_V(COEF[g])) u_mac (
            .x_i(tap_q[g]),
            .p_o(prod[g])
        );
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) acc = acc + prod[k];
    end

    // Arithmetic shift floors toward minus infinity; the cast drops acc bit 16 so large sums wrap.
    assign dout_d = DOUT_W'(acc >>> SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) tap_q[k] <= '0;
            dout_q <= '0;
        end else begin
            tap_q[0] <= din;
            for (int k = 1; k < NTAPS; k++) tap_q[k] <= tap_q[k-1];
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: tb/tb_rtl_sync_ftd.sv
// tb_rtl_sync_ftd: directed and model-checked stimulus for the 16-tap FIR
module tb_rtl_sync_ftd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  din = '0;
    logic [10:0] dout;
    int checks = 0;
    int failures = 0;
    int c [16] = '{0, 0, 1, -2, 2, 0, -7, 38, 38, -7, 0, 2, -2, 1, 0, 0};
    int m_tap [16];
    int m_exp = 0;
    int imp [16] = '{0, 0, 10, -20, 20, 0, -70, 380, 380, -70, 0, 20, -20, 10, 0, 0};
    int trn [16] = '{0, 0, 3, -7, 6, 0, -22, 118, 118, -22, 0, 6, -7, 3, 0, 0};

    rtl_sync_ftd dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic int wrap11(int v);
        return ((v + 1024) & 2047) - 1024;
    endfunction

    function automatic int dout_s();
        return int'($signed(dout));
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, wait past the edge, advance the reference model.
    task automatic cyc(int x, bit r);
        int acc;
        din = 10'(x);
        rst = r;
        @(posedge clk);
        #1;
        acc = 0;
        for (int k = 0; k < 16; k++) acc += m_tap[k] * c[k];
        if (r) begin
            m_exp = 0;
            for (int k = 0; k < 16; k++) m_tap[k] = 0;
        end else begin
            m_exp = wrap11(acc >>> 5);
            for (int k = 15; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = x;
        end
    endtask

    initial begin
        int x;
        for (int k = 0; k < 16; k++) m_tap[k] = 0;
        cyc(123, 1'b1);
        chk("rst_edge0", dout_s(), 0);
        cyc(123, 1'b1);
        chk("rst_edge1", dout_s(), 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1'b0);
            chk("post_rst_zero", dout_s(), 0);
        end
        cyc(320, 1'b0);
        chk("imp_capture", dout_s(), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1'b0);
            chk($sformatf("imp_%0d", i), dout_s(), imp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0);
            chk("imp_steady", dout_s(), 0);
        end
        for (int i = 0; i < 17; i++) cyc(511, 1'b0);
        chk("step_pos", dout_s(), 1022);
        for (int i = 0; i < 3; i++) begin
            cyc(511, 1'b0);
            chk("step_pos_hold", dout_s(), 1022);
        end
        for (int i = 0; i < 17; i++) cyc(-512, 1'b0);
        chk("step_neg", dout_s(), -1024);
        for (int i = 0; i < 3; i++) begin
            cyc(-512, 1'b0);
            chk("step_neg_hold", dout_s(), -1024);
        end
        for (int i = 0; i < 17; i++) cyc(0, 1'b0);
        chk("flush", dout_s(), 0);
        cyc(100, 1'b0);
        chk("trunc_capture", dout_s(), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1'b0);
            chk($sformatf("trunc_%0d", i), dout_s(), trn[i]);
        end
        // Largest positive sum 51118: after >>5 it is 1597, which wraps to -451 in 11 bits.
        for (int k = 15; k >= 0; k--) cyc(c[k] < 0 ? -512 : 511, 1'b0);
        cyc(0, 1'b0);
        chk("wrap_max", dout_s(), -451);
        chk("wrap_model", dout_s(), m_exp);
        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(1023)) - 512;
            cyc(x, 1'b0);
            chk("pre_rst_rand", dout_s(), m_exp);
        end
        cyc(77, 1'b1);
        chk("mid_rst", dout_s(), 0);
        for (int i = 0; i < 30; i++) begin
            x = int'($urandom_range(1023)) - 512;
            cyc(x, 1'b0);
            chk("post_rst_rand", dout_s(), m_exp);
        end
        for (int i = 0; i < 1000; i++) begin
            x = int'($urandom_range(1023)) - 512;
            cyc(x, 1'b0);
            chk("rand", dout_s(), m_exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
